// File: rtl/mem_dma_pkg.sv
// Shared constants and FSM encoding for the data-memory block-copy engine.
// BASE_ADDR/WINDOW_WORDS also define the data-memory offset used elsewhere.
package mem_dma_pkg;

    localparam logic [31:0] BASE_ADDR    = 32'h0010_0000;
    localparam int          WINDOW_WORDS = 262144;
    localparam int          LEN_W        = 18;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mem_range_check.sv
// Combinational check that [addr, addr + 4*len) lies inside the window.
// Uses 33-bit sums so an address near 2^32 cannot wrap into range.
module mem_range_check #(
    parameter int LEN_W = 18
) (
    input  logic [31:0]      i_addr,
    input  logic [LEN_W-1:0] i_len,
    input  logic [31:0]      i_base,
    input  logic [30:0]      i_window_words,
    output logic             o_in_range
);

    logic [32:0] w_end;
    logic [32:0] w_limit;

    assign w_end      = {1'b0, i_addr} + 33'({i_len, 2'b00});
    assign w_limit    = {1'b0, i_base} + {i_window_words, 2'b00};
    assign o_in_range = (i_addr >= i_base) && (w_end <= w_limit);

endmodule

// File: rtl/mem_copy_dma.sv
// Word-granular memmove engine on the single-port data-memory bus.
// Two cycles per word: READ captures rdata, WRITE stores it.
module mem_copy_dma #(
    parameter logic [31:0] BASE_ADDR    = mem_dma_pkg::BASE_ADDR,
    parameter int          WINDOW_WORDS = mem_dma_pkg::WINDOW_WORDS,
    parameter int          LEN_W        = mem_dma_pkg::LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic             mem_cs,
    output logic             mem_we
);

    import mem_dma_pkg::*;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_idx;
    logic             r_desc;
    logic             r_err;
    logic [31:0]      r_addr;
    logic [31:0]      r_hold;

    logic [31:0]      w_src;
    logic [31:0]      w_dst;
    logic             w_src_ok;
    logic             w_dst_ok;
    logic             w_ok;
    logic             w_desc;
    logic [LEN_W-1:0] w_idx0;
    logic [LEN_W-1:0] w_idx_nx;
    logic             w_last;

    function automatic logic [31:0] word_off(input logic [LEN_W-1:0] idx);
        return 32'({idx, 2'b00});
    endfunction

    assign w_src = src_addr & ~32'h3;
    assign w_dst = dst_addr & ~32'h3;
    assign w_ok  = w_src_ok && w_dst_ok;

    // Copying backwards when dst is above src keeps overlapping moves intact
    assign w_desc   = w_dst > w_src;
    assign w_idx0   = w_desc ? len_words - LEN_W'(1) : '0;
    assign w_idx_nx = r_desc ? r_idx - LEN_W'(1) : r_idx + LEN_W'(1);
    assign w_last   = r_desc ? (r_idx == '0) : (r_idx == r_len - LEN_W'(1));

    mem_range_check #(.LEN_W(LEN_W)) u_src_chk (
        .i_addr         (w_src),
        .i_len          (len_words),
        .i_base         (BASE_ADDR),
        .i_window_words (31'(WINDOW_WORDS)),
        .o_in_range     (w_src_ok)
    );

    mem_range_check #(.LEN_W(LEN_W)) u_dst_chk (
        .i_addr         (w_dst),
        .i_len          (len_words),
        .i_base         (BASE_ADDR),
        .i_window_words (31'(WINDOW_WORDS)),
        .o_in_range     (w_dst_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src  <= '0;
            r_dst  <= '0;
            r_len  <= '0;
            r_idx  <= '0;
            r_desc <= 1'b0;
            r_err  <= 1'b0;
            r_addr <= '0;
            r_hold <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_src  <= w_src;
                        r_dst  <= w_dst;
                        r_len  <= len_words;
                        r_desc <= w_desc;
                        r_idx  <= w_idx0;
                        r_err  <= !w_ok;
                        r_addr <= w_src + word_off(w_idx0);
                    end
                end
                ST_READ: begin
                    r_hold <= mem_rdata;
                    r_addr <= r_dst + word_off(r_idx);
                end
                ST_WRITE: begin
                    if (!w_last) begin
                        r_idx  <= w_idx_nx;
                        r_addr <= r_src + word_off(w_idx_nx);
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes decode from state so an async reset drops cs/we at once
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        err    = 1'b0;
        mem_cs = 1'b0;
        mem_we = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (!w_ok || len_words == '0) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next = ST_READ;
                    end
                end
            end
            ST_READ: begin
                busy   = 1'b1;
                mem_cs = 1'b1;
                w_next = ST_WRITE;
            end
            ST_WRITE: begin
                busy   = 1'b1;
                mem_cs = 1'b1;
                mem_we = 1'b1;
                w_next = w_last ? ST_DONE : ST_READ;
            end
            ST_DONE: begin
                done   = 1'b1;
                err    = r_err;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign mem_address = r_addr;
    assign mem_wdata   = r_hold;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma with a small behavioural data memory.
// Expected values are hand-computed per step.
module tb_mem_copy_dma;

    import mem_dma_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [LEN_W-1:0] len_words = '0;
    logic             busy;
    logic             done;
    logic             err;
    logic [31:0]      mem_address;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;
    logic             mem_cs;
    logic             mem_we;

    int total = 0;
    int bad = 0;
    int we_cnt = 0;
    int cs_cnt = 0;
    int done_cnt = 0;
    logic [31:0] waddr[$];

    logic [31:0] mem[0:1023];
    logic [29:0] w_off;
    logic [9:0]  w_i;
    logic        w_in;

    mem_copy_dma dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .len_words   (len_words),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_cs      (mem_cs),
        .mem_we      (mem_we)
    );

    always #5 clk = ~clk;

    assign w_off     = mem_address[31:2] - BASE_ADDR[31:2];
    assign w_i       = w_off[9:0];
    assign w_in      = (w_off[29:10] == '0);
    assign mem_rdata = w_in ? mem[w_i] : 32'h0;

    always @(posedge clk) begin
        if (mem_cs && mem_we && w_in) mem[w_i] = mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_cs) begin
            cs_cnt++;
            chk("addr_align", {30'b0, mem_address[1:0]}, 32'h0);
        end
        if (mem_cs && mem_we) begin
            we_cnt++;
            waddr.push_back(mem_address);
        end
        if (done) done_cnt++;
    end

    task automatic go(input logic [31:0] s, input logic [31:0] d,
                      input int n);
        @(negedge clk);
        src_addr  = s;
        dst_addr  = d;
        len_words = LEN_W'(n);
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output logic e);
        lat = 0;
        e   = 1'bx;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                e   = err;
                break;
            end
        end
        if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat;
        logic e;
        int we0;
        int cs0;
        int d0;

        for (int i = 0; i < 1024; i++) mem[i] = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_cs", {31'b0, mem_cs}, 32'd0);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_addr", mem_address, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic 4-word copy
        for (int i = 0; i < 4; i++) mem[i] = 32'hA0 + i;
        we0 = we_cnt;
        go(32'h0010_0000, 32'h0010_0100, 4);
        wait_done(lat, e);
        chk("t1_latency", lat, 32'd9);
        chk("t1_err", {31'b0, e}, 32'd0);
        chk("t1_we_pulses", we_cnt - we0, 32'd4);
        for (int i = 0; i < 4; i++)
            chk("t1_dst_word", mem[64 + i], 32'hA0 + i);
        @(negedge clk);
        chk("t1_done_pulse", {31'b0, done}, 32'd0);

        // overlapping forward move
        mem[0] = 32'd1;
        mem[1] = 32'd2;
        mem[2] = 32'd3;
        mem[3] = 32'd0;
        waddr.delete();
        go(32'h0010_0000, 32'h0010_0004, 3);
        wait_done(lat, e);
        chk("t2_latency", lat, 32'd7);
        chk("t2_w1", mem[1], 32'd1);
        chk("t2_w2", mem[2], 32'd2);
        chk("t2_w3", mem[3], 32'd3);
        chk("t2_nwrites", waddr.size(), 32'd3);
        if (waddr.size() == 3) begin
            chk("t2_wa0", waddr[0], 32'h0010_000C);
            chk("t2_wa1", waddr[1], 32'h0010_0008);
            chk("t2_wa2", waddr[2], 32'h0010_0004);
        end

        // zero length
        cs0 = cs_cnt;
        go(32'h0010_0000, 32'h0010_0100, 0);
        wait_done(lat, e);
        chk("t3_latency", lat, 32'd1);
        chk("t3_err", {31'b0, e}, 32'd0);
        chk("t3_no_cs", cs_cnt - cs0, 32'd0);

        // destination runs past the window
        cs0 = cs_cnt;
        go(32'h0010_0000, 32'h001F_FFFC, 2);
        wait_done(lat, e);
        chk("t4_latency", lat, 32'd1);
        chk("t4_err", {31'b0, e}, 32'd1);
        chk("t4_no_cs", cs_cnt - cs0, 32'd0);

        // source below the window
        go(32'h000F_FFFC, 32'h0010_0100, 1);
        wait_done(lat, e);
        chk("t4b_err", {31'b0, e}, 32'd1);

        // unaligned source
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        go(32'h0010_0003, 32'h0010_0200, 2);
        wait_done(lat, e);
        chk("t5_latency", lat, 32'd5);
        chk("t5_err", {31'b0, e}, 32'd0);
        chk("t5_w0", mem[128], 32'h11);
        chk("t5_w1", mem[129], 32'h22);

        // reset during the third write of an 8-word copy
        for (int i = 0; i < 8; i++) mem[i] = 32'h30 + i;
        go(32'h0010_0000, 32'h0010_0300, 8);
        repeat (6) @(negedge clk);
        chk("t6_in_write", {31'b0, mem_we}, 32'd1);
        chk("t6_wr_addr", mem_address, 32'h0010_0314);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("t6_cs_drop", {31'b0, mem_cs}, 32'd0);
        chk("t6_we_drop", {31'b0, mem_we}, 32'd0);
        chk("t6_busy_drop", {31'b0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_no_done", done_cnt - d0, 32'd0);
        chk("t6_kept7", mem[199], 32'h37);
        chk("t6_kept6", mem[198], 32'h36);
        chk("t6_not5", mem[197], 32'h0);
        go(32'h0010_0000, 32'h0010_0400, 1);
        wait_done(lat, e);
        chk("t6_fresh_lat", lat, 32'd3);
        chk("t6_fresh_err", {31'b0, e}, 32'd0);
        chk("t6_fresh_word", mem[256], 32'h30);

        // start while busy and while in DONE is ignored
        mem[0] = 32'h55;
        mem[1] = 32'h66;
        go(32'h0010_0000, 32'h0010_0500, 2);
        @(negedge clk);
        chk("t7_busy", {31'b0, busy}, 32'd1);
        src_addr  = 32'h0010_0004;
        dst_addr  = 32'h0010_0600;
        len_words = LEN_W'(1);
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, e);
        chk("t7_latency", lat, 32'd4);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        d0  = done_cnt;
        cs0 = cs_cnt;
        repeat (10) @(negedge clk);
        chk("t7_no_done", done_cnt - d0, 32'd0);
        chk("t7_no_cs", cs_cnt - cs0, 32'd0);
        chk("t7_w0", mem[320], 32'h55);
        chk("t7_w1", mem[321], 32'h66);
        chk("t7_untouched", mem[384], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_copy_dma.md
# mem_copy_dma

Word-granular block-copy initiator that drives the single-port data memory's `cs`/`we`/`address`/`data_in` port and consumes its combinational read data. It sits beside the core on the data-memory bus. On a one-cycle `start` it copies `len_words` 32-bit words from `src_addr` to `dst_addr` inside the data-memory window, with memmove-safe ordering. It then reports `done`, plus `err` if the request fell outside the window.

## Interface
- `BASE_ADDR`, 32'h0010_0000, byte address of data-memory word 0.
- `WINDOW_WORDS`, 262144, number of words in the window.
- `LEN_W`, 18, width of `len_words`.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request pulse; sampled only in IDLE.
- `src_addr` in 32: source byte address; bits [1:0] ignored (treated as 0).
- `dst_addr` in 32: destination byte address; bits [1:0] ignored.
- `len_words` in LEN_W: words to copy; 0 is legal.
- `busy` out 1: high in READ and WRITE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; 1 means the request was rejected.
- `mem_address` out 32: byte address to the memory; bits [1:0] always 0.
- `mem_wdata` out 32: write data to the memory.
- `mem_rdata` in 32: read data from the memory; combinational, valid in the same cycle `mem_cs`=1.
- `mem_cs` out 1: memory chip select.
- `mem_we` out 1: memory write enable; the memory writes on the rising edge when `mem_cs`&`mem_we`.

## Operation
- States: IDLE, READ, WRITE, DONE.
- **IDLE**
  - `mem_cs`=`mem_we`=0.
  - On `start`, latch the aligned src, dst and length, and evaluate the request.
  - Range check uses 33-bit arithmetic; no wrap is allowed. Each of src and dst must satisfy `addr >= BASE_ADDR` and `addr + 4*len <= BASE_ADDR + 4*WINDOW_WORDS`.
  - If the check fails: go to DONE with `err`=1; no memory access.
  - If `len`=0: go to DONE with `err`=0; no memory access.
  - Otherwise go to READ.
- **Direction**
  - Descending if `dst > src`: word index runs len-1 down to 0.
  - Ascending otherwise: word index 0 up to len-1.
  - Result equals memmove for any overlap.
- **READ**
  - `mem_cs`=1, `mem_we`=0, `mem_address`=src+4*i.
  - Capture `mem_rdata` into the holding register at the edge.
  - Go to WRITE.
- **WRITE**
  - `mem_cs`=1, `mem_we`=1, `mem_address`=dst+4*i, `mem_wdata`=holding register.
  - If i is the last index, go to DONE; otherwise step i and go to READ.
- **DONE**
  - `done`=1, `err` as decided, `busy`=0, `mem_cs`=0.
  - Next state is IDLE.
- `start` outside IDLE (including in DONE) is ignored and never queued.
- Outputs are registered or decoded from state only; no combinational path from `start` or `mem_rdata` to any output.

## Timing
- Reset values:
  - state IDLE.
  - `busy`, `done`, `err`, `mem_cs`, `mem_we` = 0.
  - `mem_address`, `mem_wdata`, holding register = 0.
- Reset asserted mid-copy: `mem_cs`/`mem_we` drop immediately (asynchronously). Words already written stay written; the partial copy is not reported (no `done`).
- `start` sampled at edge k, N≥1 words, valid request:
  - READ of the first word occupies cycle k+1.
  - WRITE of the first word occupies cycle k+2.
  - `done` is high during cycle k+2N+1.
  - `busy` is high during cycles k+1 through k+2N.
- Rejected request or N=0: `done` is high during cycle k+1.
- Earliest accepted new `start` is at the edge ending the DONE cycle +1; that is, the next IDLE cycle.
- Throughput: 2 cycles per word; exactly one `mem_we` cycle per word.
- `mem_wdata` is don't-care when `mem_we`=0 but is held stable (last value).

## Structure
- Shared package `mem_dma_pkg`:
  - state enum.
  - `BASE_ADDR` and `WINDOW_WORDS` defaults, which are shared with the data-memory offset constant.
- One sub-module, `mem_range_check`: purely combinational. Takes base addr, length and window; returns `in_range`. Instantiated twice (src and dst).

## Test plan
- Preload words 0x100000..0x10000C with 0xA0..0xA3; src=0x100000, dst=0x100100, len=4.
  - Required: dst holds A0..A3.
  - `done` is high exactly 9 cycles after the start edge.
  - 4 `mem_we` pulses.
- Overlap forward: memory 0x100000..0x100008 = 1,2,3; src=0x100000, dst=0x100004, len=3.
  - Required: 0x100004..0x10000C = 1,2,3.
  - Write addresses descend.
- len=0, and separately dst=0x1FFFFC with len=2.
  - Required: `done` at k+1; `err`=0 and `err`=1 respectively; `mem_cs` never asserted.
- Unaligned src=0x100003.
  - Required: behaves as 0x100000; `mem_address`[1:0] is always 0.
- Deassert `rst_n` during the 3rd WRITE of a len=8 copy.
  - Required: `mem_cs`=0 immediately; no `done`.
  - After release, a fresh len=1 copy completes normally.
- Pulse `start` with different args during `busy` and during DONE.
  - Required: ignored; original copy unaffected; no second `done`.
